fetch_stage: RTL and testbench



---
 rtl/cpu_defs_pkg.sv | 25 ++
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end definitions: PC width, fetch FSM encoding, reset
// defaults and a word-alignment helper.
// Ports: none (package).
package cpu_defs_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] DEF_RESET_PC = 32'hBFC0_0000;
  localparam logic [PC_W-1:0] DEF_NOP_INST = 32'h0000_0000;

  // S_REQ : request on the bus, waiting for addr_ok
  // S_WAIT: request accepted, waiting for data_ok
  // S_HAVE: fetched word parked in fbuf, waiting for the pipe to advance
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HAVE = 2'd2
  } fetch_state_e;

  // Instruction addresses are always word aligned.
  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, runs a single-outstanding
// req/addr_ok/data_ok fetch port, parks one fetched word and holds the F->D register.
// Ports: hazard controls (F_ena/D_ena/F_flush/D_flush), execute redirect,
// instruction memory port (inst_*), decode outputs (D_pc/D_inst/D_valid), F_busy.
module fetch_stage
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        F_ena,
  input  logic        D_ena,
  input  logic        F_flush,
  input  logic        D_flush,
  input  logic        E_branch_taken,
  input  logic [31:0] E_branch_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] D_pc,
  output logic [31:0] D_inst,
  output logic        D_valid,
  output logic        F_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         cancel_q, cancel_d;
  logic [31:0]  fbuf_q, fbuf_d;
  logic         d_valid_q;
  logic [31:0]  d_pc_q;
  logic [31:0]  d_inst_q;

  logic        advance;
  logic        kill;
  logic        data_hit;
  logic        avail;
  logic        take;
  logic [31:0] inst_sel;

  always_comb begin
    advance  = F_ena & D_ena;
    // A redirect and a fetch flush both squash the current fetch; they
    // differ only in where the PC goes.
    kill     = E_branch_taken | F_flush;
    data_hit = (state_q == S_WAIT) & inst_data_ok & ~cancel_q;
    avail    = data_hit | (state_q == S_HAVE);
    // A squashed instruction never reaches decode, even with advance high.
    take     = avail & advance & ~kill;
    inst_sel = (state_q == S_HAVE) ? fbuf_q : inst_rdata;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cancel_d = cancel_q;
    fbuf_d   = fbuf_q;

    unique case (state_q)
      S_REQ: begin
        // data_ok here can only be a leftover from before reset: ignored.
        if (inst_addr_ok) begin
          state_d  = S_WAIT;
          // The accepted request is for the old PC if we are squashing now.
          cancel_d = kill;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          // Arriving data consumes any pending cancel, including one
          // raised in this very cycle.
          cancel_d = 1'b0;
          if (cancel_q || kill || advance) begin
            state_d = S_REQ;
          end else begin
            state_d = S_HAVE;
            fbuf_d  = inst_rdata;
          end
        end else if (kill) begin
          cancel_d = 1'b1;
        end
      end
      S_HAVE: begin
        if (kill || advance) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (take) begin
      pc_d = pc_q + 32'd4;
    end
    if (E_branch_taken) begin
      pc_d = align_word(E_branch_target);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      cancel_q <= 1'b0;
      fbuf_q   <= NOP_INST;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cancel_q <= cancel_d;
      fbuf_q   <= fbuf_d;
    end
  end

  // F->D register: flush beats load, load beats bubble, otherwise hold.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      d_valid_q <= 1'b0;
      d_pc_q    <= 32'd0;
      d_inst_q  <= NOP_INST;
    end else if (D_flush) begin
      d_valid_q <= 1'b0;
      d_inst_q  <= NOP_INST;
    end else if (take) begin
      d_valid_q <= 1'b1;
      d_pc_q    <= align_word(pc_q);
      d_inst_q  <= inst_sel;
    end else if (D_ena) begin
      d_valid_q <= 1'b0;
      d_inst_q  <= NOP_INST;
    end
  end

  assign inst_req  = (state_q == S_REQ);
  assign inst_addr = align_word(pc_q);
  assign D_valid   = d_valid_q;
  assign D_pc      = d_pc_q;
  assign D_inst    = d_inst_q;
  assign F_busy    = ~avail;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level model.
// Ports: none (top-level bench).
module tb_fetch_stage;

  logic        clk;
  logic        resetn;
  logic        F_ena, D_ena, F_flush, D_flush;
  logic        E_branch_taken;
  logic [31:0] E_branch_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] D_pc, D_inst;
  logic        D_valid, F_busy;

  fetch_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .F_ena           (F_ena),
    .D_ena           (D_ena),
    .F_flush         (F_flush),
    .D_flush         (D_flush),
    .E_branch_taken  (E_branch_taken),
    .E_branch_target (E_branch_target),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .D_pc            (D_pc),
    .D_inst          (D_inst),
    .D_valid         (D_valid),
    .F_busy          (F_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Transaction-level model: a PC, at most one outstanding request (possibly
  // stale), and at most one parked instruction.
  bit          model_ok = 0;
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_stale;
  bit          m_held;
  logic [31:0] m_buf;
  bit          md_valid;
  logic [31:0] md_pc;
  logic [31:0] md_inst;
  int          mem_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic compare_model();
    bit have;
    if (!model_ok) return;
    have = m_held || (m_out && inst_data_ok && !m_stale);
    chk("req",     inst_req,  !m_out && !m_held);
    chk("addr",    inst_addr, m_pc);
    chk("busy",    F_busy,    !have);
    chk("d_valid", D_valid,   md_valid);
    chk("d_pc",    D_pc,      md_pc);
    chk("d_inst",  D_inst,    md_inst);
  endtask

  task automatic model_update();
    bit          kill, adv, have;
    logic [31:0] instr;
    if (!resetn) begin
      model_ok = 1;
      m_pc = 32'hBFC0_0000; m_out = 0; m_stale = 0; m_held = 0; m_buf = 0;
      md_valid = 0; md_pc = 0; md_inst = 32'h0;
      return;
    end
    kill  = E_branch_taken || F_flush;
    adv   = F_ena && D_ena;
    have  = m_held || (m_out && inst_data_ok && !m_stale);
    instr = m_held ? m_buf : inst_rdata;
    // Decode register
    if (D_flush) begin
      md_valid = 0; md_inst = 32'h0;
    end else if (have && adv && !kill) begin
      md_valid = 1; md_pc = m_pc; md_inst = instr;
    end else if (D_ena) begin
      md_valid = 0; md_inst = 32'h0;
    end
    // Fetch side
    if (m_out && inst_data_ok) begin
      m_out = 0;
      if (m_stale || kill) m_stale = 0;
      else if (adv) m_pc = m_pc + 32'd4;
      else begin m_held = 1; m_buf = inst_rdata; end
    end else if (m_out) begin
      if (kill) m_stale = 1;
    end else if (m_held) begin
      if (kill) m_held = 0;
      else if (adv) begin m_held = 0; m_pc = m_pc + 32'd4; end
    end else if (inst_addr_ok) begin
      m_out = 1; m_stale = kill;
    end
    if (E_branch_taken) m_pc = {E_branch_target[31:2], 2'b00};
  endtask

  task automatic step();
    #2;
    compare_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    resetn = 1; F_ena = 1; D_ena = 1; F_flush = 0; D_flush = 0;
    E_branch_taken = 0; E_branch_target = 32'h0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 32'h0;
  endtask

  initial begin
    idle();
    resetn = 0;
    step();
    step();

    // Basic fetch: addr_ok cycle 1, data_ok cycle 3, D loaded in cycle 4
    idle(); #1;
    chk("rst_req",     inst_req,  1'b1);
    chk("rst_addr",    inst_addr, 32'hBFC0_0000);
    chk("rst_d_valid", D_valid,   1'b0);
    chk("rst_d_pc",    D_pc,      32'h0);
    chk("rst_d_inst",  D_inst,    32'h0);
    step();
    idle(); inst_addr_ok = 1; step();
    idle(); step();
    idle(); inst_data_ok = 1; inst_rdata = 32'h2408_0001; step();
    idle(); #1;
    chk("t1_d_valid", D_valid,   1'b1);
    chk("t1_d_pc",    D_pc,      32'hBFC0_0000);
    chk("t1_d_inst",  D_inst,    32'h2408_0001);
    chk("t1_addr",    inst_addr, 32'hBFC0_0004);

    // Stall while data arrives, then release the parked word
    idle(); F_ena = 0; D_ena = 0; inst_addr_ok = 1; step();
    idle(); F_ena = 0; D_ena = 0; inst_data_ok = 1; inst_rdata = 32'hAAAA_5555; #1;
    chk("t2_busy_hit", F_busy, 1'b0);
    step();
    idle(); F_ena = 0; D_ena = 0; #1;
    chk("t2_busy_have", F_busy,  1'b0);
    chk("t2_req_have",  inst_req, 1'b0);
    chk("t2_d_hold_pc", D_pc,    32'hBFC0_0000);
    chk("t2_d_hold_in", D_inst,  32'h2408_0001);
    step();
    idle(); F_ena = 0; D_ena = 0; step();
    idle(); step();
    idle(); #1;
    chk("t2_d_valid", D_valid,   1'b1);
    chk("t2_d_pc",    D_pc,      32'hBFC0_0004);
    chk("t2_d_inst",  D_inst,    32'hAAAA_5555);
    chk("t2_addr",    inst_addr, 32'hBFC0_0008);

    // Redirect while waiting; the late response is dropped
    idle(); inst_addr_ok = 1; step();
    idle(); E_branch_taken = 1; E_branch_target = 32'h8000_0100; step();
    idle(); #1;
    chk("t3_req_wait", inst_req, 1'b0);
    step();
    idle(); inst_data_ok = 1; inst_rdata = 32'hDEAD_BEEF; #1;
    chk("t3_busy_stale", F_busy, 1'b1);
    step();
    idle(); #1;
    chk("t3_d_valid", D_valid,   1'b0);
    chk("t3_req",     inst_req,  1'b1);
    chk("t3_addr",    inst_addr, 32'h8000_0100);

    // Redirect in the same cycle the request is accepted; unaligned target
    idle(); inst_addr_ok = 1; E_branch_taken = 1; E_branch_target = 32'h8000_0203; step();
    idle(); #1;
    chk("t4_req_wait", inst_req, 1'b0);
    inst_data_ok = 1; inst_rdata = 32'hCAFE_F00D; #1;
    chk("t4_busy_stale", F_busy, 1'b1);
    step();
    idle(); #1;
    chk("t4_d_valid", D_valid,   1'b0);
    chk("t4_req",     inst_req,  1'b1);
    chk("t4_addr",    inst_addr, 32'h8000_0200);

    // D_flush with a deliverable instruction: lost, PC still advances
    idle(); inst_addr_ok = 1; step();
    idle(); inst_data_ok = 1; inst_rdata = 32'h1234_5678; D_flush = 1; step();
    idle(); #1;
    chk("t5_d_valid", D_valid,   1'b0);
    chk("t5_d_inst",  D_inst,    32'h0);
    chk("t5_req",     inst_req,  1'b1);
    chk("t5_addr",    inst_addr, 32'h8000_0204);

    // Reset mid-wait; the leftover response right after reset is ignored
    idle(); inst_addr_ok = 1; step();
    idle(); #1;
    chk("t6_req_wait", inst_req, 1'b0);
    resetn = 0; step();
    idle(); inst_data_ok = 1; inst_rdata = 32'h0BAD_0BAD; #1;
    chk("t6_busy", F_busy,    1'b1);
    chk("t6_req0", inst_req,  1'b1);
    chk("t6_addr0", inst_addr, 32'hBFC0_0000);
    step();
    idle(); #1;
    chk("t6_req1",    inst_req,  1'b1);
    chk("t6_addr1",   inst_addr, 32'hBFC0_0000);
    chk("t6_d_valid", D_valid,   1'b0);

    // Randomized traffic against the model
    idle(); resetn = 0; step();
    mem_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      idle();
      resetn          = ($urandom_range(0, 199) != 0);
      F_ena           = ($urandom_range(0, 3) != 0);
      D_ena           = ($urandom_range(0, 3) != 0);
      F_flush         = ($urandom_range(0, 19) == 0);
      D_flush         = ($urandom_range(0, 19) == 0);
      E_branch_taken  = ($urandom_range(0, 11) == 0);
      E_branch_target = $urandom;
      inst_addr_ok    = ($urandom_range(0, 9) < 6);
      inst_rdata      = $urandom;
      if (m_out) begin
        if (mem_cnt == 0) inst_data_ok = 1;
        else mem_cnt--;
      end else begin
        mem_cnt = $urandom_range(0, 3);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
